rf_write_scheduler: RTL
=======================

RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 SHALL expose parameters: DW, default 16, register data width; RW, default 4, register ID width; FD, default 2, load-return FIFO depth.
REQ-002 SHALL have ports: clk  in  1  clock, single domain, all state rising-edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have ports: a_valid in 1, a_ready out 1, a_reg in RW, a_data in DW  (ALU writeback requester).
REQ-005 SHALL have ports: b_valid in 1, b_ready out 1, b_reg in RW, b_data in DW  (memory load-return requester).
REQ-006 SHALL have ports: iss_valid in 1, iss_reg in RW, iss_ready out 1  (load issue, marks b_reg pending).
REQ-007 SHALL have ports: src1 in RW, src2 in RW, stall out 1  (decode-stage read-hazard query).
REQ-008 SHALL have ports: WriteReg out 1, DstReg out RW, DstData out DW  (drives the register file write port).

Function
REQ-009 SHALL transfer on a requester when valid and ready are both high on a rising edge.
REQ-010 SHALL accept every b_valid beat into an FD-entry FIFO; b_ready = FIFO not full.
REQ-011 SHALL arbitrate per cycle between A and the FIFO head: A wins unless the FIFO is full, in which case the FIFO head wins and a_ready = 0.
REQ-012 SHALL drive a_ready = 1 whenever the FIFO is not full, regardless of a_valid.
REQ-013 SHALL register the winner onto WriteReg/DstReg/DstData one cycle after the transfer (latency 1); with no winner WriteReg = 0 and DstReg/DstData hold.
REQ-014 SHALL suppress writes to register 0: the beat is consumed but WriteReg stays 0.
REQ-015 SHALL support simultaneous FIFO push (b beat) and pop (drain) in one cycle, including when full; the count is unchanged.
REQ-016 SHALL wrap FIFO read/write pointers modulo FD.
REQ-017 SHALL keep a per-register pending scoreboard (bit 0 tied 0); an accepted issue sets pending[iss_reg].
REQ-018 SHALL clear pending[r] on the cycle the FIFO head with reg r is written out.
REQ-019 SHALL give set priority over clear on the same register in the same cycle.
REQ-020 SHALL drive iss_ready = ~pending[iss_reg] (WAW guard); issue to register 0 is always ready and sets nothing.
REQ-021 SHALL drive stall combinationally = pending[src1] | pending[src2].
REQ-022 SHALL treat an A write to a pending register as legal; this write SHALL NOT clear the pending bit.

Reset
REQ-023 SHALL, on rst, asynchronously clear: WriteReg=0, DstReg=0, DstData=0, FIFO empty (b_ready=1, a_ready=1), all pending bits 0 (stall=0, iss_ready=1).
REQ-024 SHALL, when rst is asserted mid-transfer, discard all in-flight and buffered beats without a write-port pulse.

Structure
REQ-025 SHALL place DW, RW, FD defaults and the {REQ_A, REQ_B, REQ_NONE} grant encoding in the shared CPU package.
REQ-026 SHALL implement the load-return buffer as one sub-module, rf_ret_fifo (push/pop/full/empty/head).

Verification
REQ-027 SHALL cover: a_valid, a_reg=3, a_data=16'h1234, no B -> next cycle WriteReg=1, DstReg=3, DstData=16'h1234.
REQ-028 SHALL cover: A and B valid every cycle, A regs 1,2,3, B regs 4,5,6 -> B buffers 2, b_ready=0, then a_ready=0 one cycle while reg 4 drains; no beat is lost or reordered within B.
REQ-029 SHALL cover: iss reg 7, then src1=7 -> stall=1 until B beat reg 7 reaches the write port, stall=0 the following cycle; second iss of reg 7 meanwhile sees iss_ready=0.
REQ-030 SHALL cover: same-cycle issue reg 5 and FIFO head write of reg 5 -> pending[5] stays 1.
REQ-031 SHALL cover: a_reg=0, a_data=16'hFFFF -> beat consumed, WriteReg stays 0.
REQ-032 SHALL cover: rst pulse with FIFO full and 3 regs pending -> all outputs at reset values, no WriteReg pulse after release.

Source files
------------

// File: rtl/rf_write_scheduler_pkg.sv
// Shared definitions for the register-file write scheduler: default widths,
// FIFO depth and the write-port grant encoding.
package rf_write_scheduler_pkg;

   localparam int DW_DEF = 16;
   localparam int RW_DEF = 4;
   localparam int FD_DEF = 2;

   typedef enum logic [1:0] {
      REQ_A    = 2'd0,
      REQ_B    = 2'd1,
      REQ_NONE = 2'd2
   } grant_t;

endpackage

// File: rtl/rf_write_scheduler_ret_fifo.sv
// Load-return buffer: FD-entry FIFO carrying {reg, data} beats, with pointers
// that wrap modulo FD. A push is also accepted when full if a pop happens in the same cycle.
module rf_ret_fifo #(
   parameter int DW = 16,
   parameter int RW = 4,
   parameter int FD = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [RW-1:0] push_reg,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [RW-1:0] head_reg,
   output logic [DW-1:0] head_data
);

   localparam int PW = (FD > 1) ? $clog2(FD) : 1;
   localparam int CW = $clog2(FD + 1);

   logic [RW-1:0] reg_mem  [FD];
   logic [DW-1:0] data_mem [FD];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full      = (count == CW'(FD));
   assign empty     = (count == '0);
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_reg  = reg_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         if (do_push & ~do_pop)      count <= count + 1'b1;
         else if (do_pop & ~do_push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible once count says so.
   always_ff @(posedge clk) begin
      if (do_push) begin
         reg_mem[wr_ptr]  <= push_reg;
         data_mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU writebacks against
// buffered load returns and tracks pending load destinations for hazard stalls.
module rf_write_scheduler
   import rf_write_scheduler_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF,
   parameter int FD = FD_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [RW-1:0] a_reg,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [RW-1:0] b_reg,
   input  logic [DW-1:0] b_data,
   input  logic          iss_valid,
   input  logic [RW-1:0] iss_reg,
   output logic          iss_ready,
   input  logic [RW-1:0] src1,
   input  logic [RW-1:0] src2,
   output logic          stall,
   output logic          WriteReg,
   output logic [RW-1:0] DstReg,
   output logic [DW-1:0] DstData
);

   localparam int NR = 2 ** RW;

   logic          fifo_full;
   logic          fifo_empty;
   logic [RW-1:0] head_reg;
   logic [DW-1:0] head_data;
   logic          fifo_push;
   logic          fifo_pop;
   grant_t        grant;
   logic [NR-1:0] pending;
   logic [NR-1:0] pending_next;
   logic          iss_accept;

   rf_ret_fifo #(.DW(DW), .RW(RW), .FD(FD)) u_ret_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_reg  (b_reg),
      .push_data (b_data),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_reg  (head_reg),
      .head_data (head_data)
   );

   // A full buffer must drain, so it takes the port and back-pressures A.
   always_comb begin
      grant = REQ_NONE;
      if (fifo_full)        grant = REQ_B;
      else if (a_valid)     grant = REQ_A;
      else if (!fifo_empty) grant = REQ_B;
   end

   assign a_ready   = ~fifo_full;
   assign b_ready   = ~fifo_full;
   assign fifo_push = b_valid & b_ready;
   assign fifo_pop  = (grant == REQ_B);

   assign iss_ready  = ~pending[iss_reg];
   assign iss_accept = iss_valid & iss_ready & (iss_reg != '0);
   assign stall      = pending[src1] | pending[src2];

   // Clear first so a same-cycle issue of the draining register wins.
   always_comb begin
      pending_next = pending;
      if (grant == REQ_B) pending_next[head_reg] = 1'b0;
      if (iss_accept)     pending_next[iss_reg]  = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= pending_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WriteReg <= 1'b0;
         DstReg   <= '0;
         DstData  <= '0;
      end else begin
         WriteReg <= 1'b0;
         case (grant)
            REQ_A: begin
               if (a_reg != '0) begin
                  WriteReg <= 1'b1;
                  DstReg   <= a_reg;
                  DstData  <= a_data;
               end
            end
            REQ_B: begin
               if (head_reg != '0) begin
                  WriteReg <= 1'b1;
                  DstReg   <= head_reg;
                  DstData  <= head_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
